mod_updown_counter: RTL and testbench

- Parametrised successor to the team's free-running 7-bit up counter.
- Adds a programmable modulus, up/down direction, count enable, synchronous clear and parallel load, and wrap or saturate end behaviour.
- Provides terminal-count, carry/borrow and sticky saturation outputs for cascading into timer and display chains clocked by the slow system tick.
- Single clock domain.

---
 rtl/cnt_pkg.sv | 16 +
 rtl/mod_updown_counter.sv | 84 ++++++++
 tb/tb_mod_updown_counter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/cnt_pkg.sv
// Shared constants and helpers for the up/down modulus counter family.
package cnt_pkg;

  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;

  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

  // Values past the last legal state load as the last legal state.
  function automatic longint unsigned clamp_mod(input longint unsigned value,
                                                input longint unsigned modulus);
    return (value <= modulus - 64'd1) ? value : modulus - 64'd1;
  endfunction

endpackage

// File: rtl/mod_updown_counter.sv
// Modulus-N up/down counter with clear, clamped parallel load, wrap or saturate
// end behaviour, combinational terminal count, carry pulse and sticky saturation.
module mod_updown_counter
  import cnt_pkg::*;
#(
  parameter int              WIDTH    = 7,
  parameter longint unsigned MODULUS  = 128,
  parameter int              SATURATE = CNT_WRAP
) (
  input  logic             clk_1Hz,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             carry,
  output logic             sat
);

  if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_param
    $error("mod_updown_counter: illegal WIDTH/MODULUS combination");
  end

  // Held at WIDTH+1 bits so MODULUS = 2^WIDTH needs no special case.
  localparam logic [WIDTH:0] MAX_V = (WIDTH+1)'(MODULUS - 64'd1);

  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] count_dec;
  logic [WIDTH-1:0] load_clamped;

  assign at_max       = ({1'b0, count} == MAX_V);
  assign at_zero      = (count == '0);
  assign count_inc    = WIDTH'({1'b0, count} + (WIDTH+1)'(1));
  assign count_dec    = WIDTH'({1'b0, count} - (WIDTH+1)'(1));
  assign load_clamped = WIDTH'(clamp_mod(64'(load_val), MODULUS));

  // Combinational so the next stage of a cascade can use it as its enable.
  assign tc = en & ((up_dn == CNT_UP) ? at_max : at_zero);

  always_ff @(posedge clk_1Hz) begin
    if (rst) begin
      count <= '0;
      carry <= 1'b0;
      sat   <= 1'b0;
    end else if (clear) begin
      count <= '0;
      carry <= 1'b0;
      sat   <= 1'b0;
    end else if (load) begin
      count <= load_clamped;
      carry <= 1'b0;
      sat   <= 1'b0;
    end else if (en) begin
      carry <= 1'b0;
      if (up_dn == CNT_UP) begin
        if (!at_max) begin
          count <= count_inc;
        end else if (SATURATE == CNT_SAT) begin
          sat <= 1'b1;
        end else begin
          count <= '0;
          carry <= 1'b1;
        end
      end else begin
        if (!at_zero) begin
          count <= count_dec;
        end else if (SATURATE == CNT_SAT) begin
          sat <= 1'b1;
        end else begin
          count <= WIDTH'(MAX_V);
          carry <= 1'b1;
        end
      end
    end else begin
      carry <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: three variants (mod-100 wrap, mod-100 saturate,
// mod-128 wrap) share one stimulus stream and are checked against hand-computed tables.
module tb_mod_updown_counter;

  logic       clk_1Hz;
  logic       rst;
  logic       en;
  logic       up_dn;
  logic       clear;
  logic       load;
  logic [6:0] load_val;

  logic [6:0] cnt_w, cnt_s, cnt_f;
  logic       tc_w, tc_s, tc_f;
  logic       car_w, car_s, car_f;
  logic       sat_w, sat_s, sat_f;

  int n_cmp;
  int n_err;

  // ---------------- clock / reset ----------------
  initial clk_1Hz = 1'b0;
  always #5 clk_1Hz = ~clk_1Hz;

  mod_updown_counter #(.WIDTH(7), .MODULUS(100), .SATURATE(0)) u_wrap (
    .clk_1Hz(clk_1Hz), .rst(rst), .en(en), .up_dn(up_dn), .clear(clear),
    .load(load), .load_val(load_val),
    .count(cnt_w), .tc(tc_w), .carry(car_w), .sat(sat_w)
  );

  mod_updown_counter #(.WIDTH(7), .MODULUS(100), .SATURATE(1)) u_sat (
    .clk_1Hz(clk_1Hz), .rst(rst), .en(en), .up_dn(up_dn), .clear(clear),
    .load(load), .load_val(load_val),
    .count(cnt_s), .tc(tc_s), .carry(car_s), .sat(sat_s)
  );

  mod_updown_counter #(.WIDTH(7), .MODULUS(128), .SATURATE(0)) u_full (
    .clk_1Hz(clk_1Hz), .rst(rst), .en(en), .up_dn(up_dn), .clear(clear),
    .load(load), .load_val(load_val),
    .count(cnt_f), .tc(tc_f), .carry(car_f), .sat(sat_f)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst, clear, load, en, up_dn;
    logic [6:0] val;
    int         w_cnt;
    logic       w_car, w_tc;
    int         s_cnt;
    logic       s_sat, s_car;
    int         f_cnt;
    logic       f_car;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  function automatic vec_t mk(logic r, logic c, logic l, logic e, logic u, int v,
                              int wc, logic wcar, logic wtc,
                              int sc, logic ssat, logic scar,
                              int fc, logic fcar);
    vec_t t;
    t.rst = r; t.clear = c; t.load = l; t.en = e; t.up_dn = u; t.val = 7'(v);
    t.w_cnt = wc; t.w_car = wcar; t.w_tc = wtc;
    t.s_cnt = sc; t.s_sat = ssat; t.s_car = scar;
    t.f_cnt = fc; t.f_car = fcar;
    return t;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_1Hz);
    #1;
  endtask

  task automatic drive(logic r, logic c, logic l, logic e, logic u, logic [6:0] v);
    rst = r; clear = c; load = l; en = e; up_dn = u; load_val = v;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  logic [6:0] exp_q[$];
  int         carries;
  int         model;

  initial begin
    // rst with load/en also high, then release and step
    vecs[0]  = mk(1,0,1,1,1,  5,   0,0,0,   0,0,0,   0,0);
    vecs[1]  = mk(1,0,1,1,1,  5,   0,0,0,   0,0,0,   0,0);
    vecs[2]  = mk(0,0,0,1,1,  0,   1,0,0,   1,0,0,   1,0);
    // wrap / saturate at the top
    vecs[3]  = mk(0,0,1,1,1, 98,  98,0,0,  98,0,0,  98,0);
    vecs[4]  = mk(0,0,0,1,1,  0,  99,0,1,  99,0,0,  99,0);
    vecs[5]  = mk(0,0,0,1,1,  0,   0,1,0,  99,1,0, 100,0);
    vecs[6]  = mk(0,0,0,1,1,  0,   1,0,0,  99,1,0, 101,0);
    // borrow / saturate at the bottom
    vecs[7]  = mk(0,0,1,1,0,  1,   1,0,0,   1,0,0,   1,0);
    vecs[8]  = mk(0,0,0,1,0,  0,   0,0,1,   0,0,0,   0,0);
    vecs[9]  = mk(0,0,0,1,0,  0,  99,1,0,   0,1,0, 127,1);
    vecs[10] = mk(0,0,0,1,0,  0,  98,0,0,   0,1,0, 126,0);
    // idle hold, clamped load clears sat, clear
    vecs[11] = mk(0,0,0,0,0,  0,  98,0,0,   0,1,0, 126,0);
    vecs[12] = mk(0,0,1,0,1,120,  99,0,0,  99,0,0, 120,0);
    vecs[13] = mk(0,1,0,1,0,  0,   0,0,1,   0,0,0,   0,0);
    // clear beats load; load beats en
    vecs[14] = mk(0,1,1,1,1, 50,   0,0,0,   0,0,0,   0,0);
    vecs[15] = mk(0,0,1,1,1, 10,  10,0,0,  10,0,0,  10,0);
    // direction change mid-count
    vecs[16] = mk(0,0,0,1,1,  0,  11,0,0,  11,0,0,  11,0);
    vecs[17] = mk(0,0,0,1,0,  0,  10,0,0,  10,0,0,  10,0);
    vecs[18] = mk(0,0,0,1,0,  0,   9,0,0,   9,0,0,   9,0);
    // rst beats load
    vecs[19] = mk(1,0,1,1,1, 60,   0,0,0,   0,0,0,   0,0);

    n_cmp = 0;
    n_err = 0;
    drive(1, 0, 0, 0, 1, 0);
    #1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].clear, vecs[i].load, vecs[i].en, vecs[i].up_dn, vecs[i].val);
      tick();
      chk("wrap_count",  i, 32'(cnt_w), 32'(vecs[i].w_cnt));
      chk("wrap_carry",  i, 32'(car_w), 32'(vecs[i].w_car));
      chk("wrap_tc",     i, 32'(tc_w),  32'(vecs[i].w_tc));
      chk("wrap_sat",    i, 32'(sat_w), 32'(0));
      chk("sat_count",   i, 32'(cnt_s), 32'(vecs[i].s_cnt));
      chk("sat_sat",     i, 32'(sat_s), 32'(vecs[i].s_sat));
      chk("sat_carry",   i, 32'(car_s), 32'(vecs[i].s_car));
      chk("full_count",  i, 32'(cnt_f), 32'(vecs[i].f_cnt));
      chk("full_carry",  i, 32'(car_f), 32'(vecs[i].f_car));
    end

    // Full range: 256 up steps from 0 on the mod-128 instance
    drive(0, 0, 1, 0, 1, 0);
    tick();
    chk("full_load0", 0, 32'(cnt_f), 32'(0));
    model   = 0;
    carries = 0;
    drive(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 256; i++) begin
      chk("full_tc", i, 32'(tc_f), 32'(model == 127));
      model = (model + 1) % 128;
      exp_q.push_back(7'(model));
      tick();
      chk("full_run_count", i, 32'(cnt_f), 32'(exp_q.pop_front()));
      chk("full_run_carry", i, 32'(car_f), 32'(model == 0));
      if (car_f) carries++;
    end
    chk("full_carry_total", 0, 32'(carries), 32'(2));

    // A few more steps, then a mid-sequence reset
    for (int i = 0; i < 3; i++) tick();
    chk("full_pre_rst", 0, 32'(cnt_f), 32'(3));
    drive(1, 0, 0, 1, 1, 0);
    tick();
    chk("full_mid_rst", 0, 32'(cnt_f), 32'(0));
    chk("wrap_mid_rst", 0, 32'(cnt_w), 32'(0));
    drive(0, 0, 0, 1, 1, 0);
    tick();
    chk("full_post_rst", 0, 32'(cnt_f), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
